// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle main control unit:
// opcodes, ALU-op classes, mux encodings and FSM state codes.
package multicycle_control_pkg;

    localparam int OP_RTYPE = 0;
    localparam int OP_J     = 2;
    localparam int OP_BEQ   = 4;
    localparam int OP_ADDI  = 8;
    localparam int OP_LW    = 35;
    localparam int OP_SW    = 43;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_OUT = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    localparam logic [3:0] S_RST     = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADR  = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_REXEC   = 4'd7;
    localparam logic [3:0] S_RWB     = 4'd8;
    localparam logic [3:0] S_AEXEC   = 4'd9;
    localparam logic [3:0] S_AWB     = 4'd10;
    localparam logic [3:0] S_BEQ     = 4'd11;
    localparam logic [3:0] S_JUMP    = 4'd12;
    localparam logic [3:0] S_ILLEGAL = 4'd13;

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: steps each instruction through
// fetch/decode/execute/memory/write-back, stalling on mem_ready.
module multicycle_control #(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter bit ENABLE_JUMP = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_src,
    output logic                instr_done,
    output logic                illegal_op
);
    import multicycle_control_pkg::*;

    logic [3:0] state;
    logic [3:0] state_nx;
    logic       is_lw;

    // Next-state selection; unused encodings fall back to RST
    always_comb begin
        state_nx = S_RST;
        unique case (state)
            S_RST:    state_nx = S_FETCH;
            S_FETCH:  state_nx = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OPCODE_W'(OP_LW) ||
                    opcode == OPCODE_W'(OP_SW))
                    state_nx = S_MEMADR;
                else if (opcode == OPCODE_W'(OP_RTYPE))
                    state_nx = S_REXEC;
                else if (opcode == OPCODE_W'(OP_BEQ))
                    state_nx = S_BEQ;
                else if (opcode == OPCODE_W'(OP_ADDI))
                    state_nx = S_AEXEC;
                else if (ENABLE_JUMP &&
                         opcode == OPCODE_W'(OP_J))
                    state_nx = S_JUMP;
                else
                    state_nx = S_ILLEGAL;
            end
            S_MEMADR: state_nx = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nx = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nx = mem_ready ? S_FETCH : S_MEMWR;
            S_REXEC:  state_nx = S_RWB;
            S_AEXEC:  state_nx = S_AWB;
            S_MEMWB, S_RWB, S_AWB, S_BEQ,
            S_JUMP, S_ILLEGAL:
                      state_nx = S_FETCH;
            default:  state_nx = S_RST;
        endcase
    end

    // State register; lw/sw choice latched in DECODE for MEMADR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
            is_lw <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE)
                is_lw <= (opcode == OPCODE_W'(OP_LW));
        end
    end

    // Control word decoded from state; mem_ready only completes a memory handshake
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_W'(ALU_ADD);
        pc_src        = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM4;
            S_MEMADR, S_AEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            S_REXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(ALU_FUNCT);
            end
            S_RWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_AWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_W'(ALU_SUB);
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_OUT;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PCSRC_JMP;
                instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: per-cycle expected control words from a
// rule-level instruction model, checked on two jump configurations.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;

    logic       pcw_j, pcc_j, iord_j, mrd_j, mwr_j, irw_j;
    logic       m2r_j, rdst_j, rw_j, sa_j, done_j, ill_j;
    logic [1:0] sb_j, aop_j, psrc_j;
    logic       pcw_n, pcc_n, iord_n, mrd_n, mwr_n, irw_n;
    logic       m2r_n, rdst_n, rw_n, sa_n, done_n, ill_n;
    logic [1:0] sb_n, aop_n, psrc_n;

    always #5 clk = ~clk;

    multicycle_control #(.ENABLE_JUMP(1'b1)) dut_j (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .mem_ready(mem_ready),
        .pc_write(pcw_j), .pc_write_cond(pcc_j),
        .iord(iord_j), .mem_read(mrd_j), .mem_write(mwr_j),
        .ir_write(irw_j), .mem_to_reg(m2r_j),
        .reg_dst(rdst_j), .reg_write(rw_j),
        .alu_src_a(sa_j), .alu_src_b(sb_j), .alu_op(aop_j),
        .pc_src(psrc_j), .instr_done(done_j),
        .illegal_op(ill_j)
    );

    multicycle_control #(.ENABLE_JUMP(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .mem_ready(mem_ready),
        .pc_write(pcw_n), .pc_write_cond(pcc_n),
        .iord(iord_n), .mem_read(mrd_n), .mem_write(mwr_n),
        .ir_write(irw_n), .mem_to_reg(m2r_n),
        .reg_dst(rdst_n), .reg_write(rw_n),
        .alu_src_a(sa_n), .alu_src_b(sb_n), .alu_op(aop_n),
        .pc_src(psrc_n), .instr_done(done_n),
        .illegal_op(ill_n)
    );

    logic [17:0] w_j, w_n;
    assign w_j = {pcw_j, pcc_j, iord_j, mrd_j, mwr_j, irw_j,
                  m2r_j, rdst_j, rw_j, sa_j, sb_j, aop_j,
                  psrc_j, done_j, ill_j};
    assign w_n = {pcw_n, pcc_n, iord_n, mrd_n, mwr_n, irw_n,
                  m2r_n, rdst_n, rw_n, sa_n, sb_n, aop_n,
                  psrc_n, done_n, ill_n};

    // control-word fields, named by datapath meaning
    localparam logic [17:0] PCW  = 18'h1 << 17;
    localparam logic [17:0] PCC  = 18'h1 << 16;
    localparam logic [17:0] IORD = 18'h1 << 15;
    localparam logic [17:0] MRD  = 18'h1 << 14;
    localparam logic [17:0] MWR  = 18'h1 << 13;
    localparam logic [17:0] IRW  = 18'h1 << 12;
    localparam logic [17:0] M2R  = 18'h1 << 11;
    localparam logic [17:0] RDST = 18'h1 << 10;
    localparam logic [17:0] RW   = 18'h1 << 9;
    localparam logic [17:0] SRCA = 18'h1 << 8;
    localparam logic [17:0] B4   = 18'h1 << 6;
    localparam logic [17:0] BIMM = 18'h2 << 6;
    localparam logic [17:0] BSH  = 18'h3 << 6;
    localparam logic [17:0] ASUB = 18'h1 << 4;
    localparam logic [17:0] AFN  = 18'h2 << 4;
    localparam logic [17:0] POUT = 18'h1 << 2;
    localparam logic [17:0] PJMP = 18'h2 << 2;
    localparam logic [17:0] DONE = 18'h1 << 1;
    localparam logic [17:0] ILL  = 18'h1;

    localparam logic [17:0] ZERO = 18'h0;
    localparam logic [17:0] F_WAIT = MRD | B4;
    localparam logic [17:0] F_GO = MRD | B4 | IRW | PCW;
    localparam logic [17:0] DEC = BSH;
    localparam logic [17:0] ADDR = SRCA | BIMM;

    typedef struct packed {
        logic [17:0] ej;
        logic [17:0] en;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int issued = 0;
    int seen = 0;
    int cyc = 0;

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input logic mr, input logic [5:0] op,
                        input logic [17:0] ej,
                        input logic [17:0] en);
        @(posedge clk);
        #1;
        mem_ready = mr;
        opcode = op;
        q.push_back('{ej: ej, en: en});
    endtask

    // fw/mw: cycles memory stays busy in fetch and in the data access
    task automatic do_instr(input logic [5:0] op, input int fw,
                            input int mw, input bit counted);
        for (int i = 0; i < fw; i++)
            step(1'b0, rnd6(), F_WAIT, F_WAIT);
        step(1'b1, rnd6(), F_GO, F_GO);
        step(rbit(), op, DEC, DEC);
        case (op)
            6'd35: begin
                step(rbit(), rnd6(), ADDR, ADDR);
                for (int i = 0; i < mw; i++)
                    step(1'b0, rnd6(), IORD | MRD, IORD | MRD);
                step(1'b1, rnd6(), IORD | MRD, IORD | MRD);
                step(rbit(), rnd6(), M2R | RW | DONE,
                     M2R | RW | DONE);
            end
            6'd43: begin
                step(rbit(), rnd6(), ADDR, ADDR);
                for (int i = 0; i < mw; i++)
                    step(1'b0, rnd6(), IORD | MWR, IORD | MWR);
                step(1'b1, rnd6(), IORD | MWR | DONE,
                     IORD | MWR | DONE);
            end
            6'd0: begin
                step(rbit(), rnd6(), SRCA | AFN, SRCA | AFN);
                step(rbit(), rnd6(), RDST | RW | DONE,
                     RDST | RW | DONE);
            end
            6'd8: begin
                step(rbit(), rnd6(), ADDR, ADDR);
                step(rbit(), rnd6(), RW | DONE, RW | DONE);
            end
            6'd4:
                step(rbit(), rnd6(),
                     SRCA | ASUB | PCC | POUT | DONE,
                     SRCA | ASUB | PCC | POUT | DONE);
            6'd2:
                step(rbit(), rnd6(), PCW | PJMP | DONE,
                     ILL | DONE);
            default:
                step(rbit(), rnd6(), ILL | DONE, ILL | DONE);
        endcase
        if (counted) issued++;
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++)
            step(rbit(), rnd6(), ZERO, ZERO);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.push_back('{ej: ZERO, en: ZERO});
    endtask

    // monitor: one expected control word per clock
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && done_j) seen++;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (w_j !== e.ej) begin
                    miscompares++;
                    $display("FAIL ctl_j cyc %0d got %h want %h",
                             cyc, w_j, e.ej);
                end
                vectors++;
                if (w_n !== e.en) begin
                    miscompares++;
                    $display("FAIL ctl_nj cyc %0d got %h want %h",
                             cyc, w_n, e.en);
                end
            end
            if ((mrd_j && mwr_j) || (mrd_n && mwr_n)) begin
                miscompares++;
                $display("FAIL rd_wr_excl cyc %0d got 1 want 0",
                         cyc);
            end
        end
    end

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        ops = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43, 6'd63};

        hold_reset(3);
        do_instr(6'd35, 0, 0, 1'b1);
        do_instr(6'd43, 0, 3, 1'b1);
        do_instr(6'd0, 0, 0, 1'b1);
        do_instr(6'd4, 0, 0, 1'b1);
        do_instr(6'd63, 0, 0, 1'b1);
        do_instr(6'd2, 1, 0, 1'b1);
        do_instr(6'd8, 2, 0, 1'b1);

        // reset dropped mid-way through a load's memory read
        step(1'b1, rnd6(), F_GO, F_GO);
        step(1'b0, 6'd35, DEC, DEC);
        step(1'b0, rnd6(), ADDR, ADDR);
        step(1'b0, rnd6(), IORD | MRD, IORD | MRD);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (w_j !== ZERO || w_n !== ZERO) begin
            miscompares++;
            $display("FAIL async_rst got %h/%h want 0", w_j, w_n);
        end
        hold_reset(2);
        do_instr(6'd35, 1, 2, 1'b1);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 4) == 0) op = rnd6();
            else op = ops[$urandom_range(0, 6)];
            do_instr(op, $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'b1);
        end

        for (int i = 0; i < 5 && q.size() > 0; i++)
            @(negedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d left want 0", q.size());
        end
        vectors++;
        if (seen != issued) begin
            miscompares++;
            $display("FAIL done_count got %0d want %0d",
                     seen, issued);
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
